// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
// The LFSR constants are used only when DMEM_RAND_LATENCY_EN is defined.
package dmem_pkg;

  localparam int ADDR_W_DEF = 12;
  localparam int DATA_W_DEF = 32;

  // Fibonacci taps for x^16+x^14+x^13+x^11+1 (state bits 15,13,12,10)
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/dmem_responder_if.sv
// Cache-to-memory word request bus, seen from the cache (master) or the memory (slave).
interface dmem_responder_if
  import dmem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) ();

  logic                  D_MEM_CSN;
  logic                  D_MEM_WEN;
  logic [ADDR_W-1:0]     D_MEM_ADDR;
  logic [DATA_W-1:0]     D_MEM_DOUT;
  logic [DATA_W/8-1:0]   D_MEM_BE;
  logic [DATA_W-1:0]     D_MEM_DI;
  logic                  D_MEM_RDY;

  modport master (
    output D_MEM_CSN, D_MEM_WEN, D_MEM_ADDR, D_MEM_DOUT, D_MEM_BE,
    input  D_MEM_DI, D_MEM_RDY
  );

  modport slave (
    input  D_MEM_CSN, D_MEM_WEN, D_MEM_ADDR, D_MEM_DOUT, D_MEM_BE,
    output D_MEM_DI, D_MEM_RDY
  );

endinterface

// File: rtl/dmem_lfsr16.sv
// 16-bit Fibonacci LFSR that steps once per asserted advance.
// Supplies the random extra wait cycles when DMEM_RAND_LATENCY_EN is defined.
module dmem_lfsr16
  import dmem_pkg::*;
(
  input  logic        CLK,
  input  logic        RSTn,
  input  logic        advance,
  output logic [15:0] value
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (advance) begin
      lfsr_d = {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign value = lfsr_q;

endmodule

// File: rtl/dmem_responder.sv
// Word memory answering cache requests after programmable wait states with a one-cycle RDY.
// Define DMEM_RAND_LATENCY_EN to add 0..3 LFSR-chosen extra wait cycles per access.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int DEPTH   = 4096,
  parameter int LATENCY = 2
) (
  input  logic             CLK,
  input  logic             RSTn,
  dmem_responder_if.slave  bus,
  output logic [31:0]      RD_COUNT,
  output logic [31:0]      WR_COUNT
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int LANES = DATA_W / 8;
  localparam int CNT_W = 5;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    waitCnt_q, waitCnt_d;
  logic [DATA_W-1:0]   rdData_q, rdData_d;
  logic [31:0]         rdCount_q, rdCount_d;
  logic [31:0]         wrCount_q, wrCount_d;
  logic [CNT_W-1:0]    loadCnt;
  logic                accept;
  logic                doAccess;
  logic [IDX_W-1:0]    idx;

  logic [DATA_W-1:0]   mem [DEPTH];

  assign idx    = bus.D_MEM_ADDR[IDX_W-1:0];
  assign accept = (state_q == IDLE) && !bus.D_MEM_CSN;

`ifdef DMEM_RAND_LATENCY_EN
  logic [15:0] lfsrVal;

  dmem_lfsr16 uLfsr (
    .CLK     (CLK),
    .RSTn    (RSTn),
    .advance (accept),
    .value   (lfsrVal)
  );

  assign loadCnt = CNT_W'(LATENCY - 1) + CNT_W'(lfsrVal[1:0]);
`else
  assign loadCnt = CNT_W'(LATENCY - 1);
`endif

  // Dropping CSN while BUSY abandons the request, even on the edge the access would happen.
  always_comb begin
    state_d   = state_q;
    waitCnt_d = waitCnt_q;
    doAccess  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d   = BUSY;
          waitCnt_d = loadCnt;
        end
      end
      BUSY: begin
        if (bus.D_MEM_CSN) begin
          state_d = IDLE;
        end else if (waitCnt_q != '0) begin
          waitCnt_d = waitCnt_q - 1'b1;
        end else begin
          doAccess = 1'b1;
          state_d  = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    rdData_d  = rdData_q;
    rdCount_d = rdCount_q;
    wrCount_d = wrCount_q;
    if (doAccess && bus.D_MEM_WEN) begin
      rdData_d  = mem[idx];
      rdCount_d = rdCount_q + 32'd1;
    end else if (doAccess) begin
      wrCount_d = wrCount_q + 32'd1;
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q   <= IDLE;
      waitCnt_q <= '0;
      rdData_q  <= '0;
      rdCount_q <= '0;
      wrCount_q <= '0;
    end else begin
      state_q   <= state_d;
      waitCnt_q <= waitCnt_d;
      rdData_q  <= rdData_d;
      rdCount_q <= rdCount_d;
      wrCount_q <= wrCount_d;
    end
  end

  // Storage has no reset so its contents survive RSTn.
  always_ff @(posedge CLK) begin
    if (doAccess && !bus.D_MEM_WEN) begin
      for (int i = 0; i < LANES; i++) begin
        if (bus.D_MEM_BE[i]) begin
          mem[idx][i*8 +: 8] <= bus.D_MEM_DOUT[i*8 +: 8];
        end
      end
    end
  end

  assign bus.D_MEM_DI  = rdData_q;
  assign bus.D_MEM_RDY = (state_q == DONE);
  assign RD_COUNT      = rdCount_q;
  assign WR_COUNT      = wrCount_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: directed scenarios plus random traffic
// checked against a word-array reference model.
module tb_dmem_responder;
  import dmem_pkg::*;

  localparam int LATENCY = 2;
  localparam int REGION  = 128;

  typedef struct {
    bit          rd;
    logic [31:0] data;
  } exp_t;

  logic        CLK;
  logic        RSTn;
  logic [31:0] RD_COUNT;
  logic [31:0] WR_COUNT;

  exp_t        expQ[$];
  logic [31:0] model [4096];
  logic [31:0] lastRead;
  int          expRd;
  int          expWr;
  int          checks;
  int          errors;

  dmem_responder_if #(.ADDR_W(12), .DATA_W(32)) bus ();

  dmem_responder #(
    .ADDR_W  (12),
    .DATA_W  (32),
    .DEPTH   (4096),
    .LATENCY (LATENCY)
  ) dut (
    .CLK      (CLK),
    .RSTn     (RSTn),
    .bus      (bus),
    .RD_COUNT (RD_COUNT),
    .WR_COUNT (WR_COUNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mergeBytes(input logic [31:0] old, input logic [31:0] d,
                                             input logic [3:0] be);
    logic [31:0] mask;
    mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    return (old & ~mask) | (d & mask);
  endfunction

  // Drives one request, records the expected response, and times RDY from the drive point.
  task automatic applyStimulus(input bit rd, input logic [11:0] a, input logic [31:0] d,
                               input logic [3:0] be, input int expEdges, input bit holdAfter);
    exp_t e;
    int   edges;
    bus.D_MEM_CSN  = 1'b0;
    bus.D_MEM_WEN  = rd;
    bus.D_MEM_ADDR = a;
    bus.D_MEM_DOUT = d;
    bus.D_MEM_BE   = be;
    e.rd   = rd;
    e.data = model[a];
    if (!rd) model[a] = mergeBytes(model[a], d, be);
    expQ.push_back(e);
    edges = 0;
    do begin
      @(posedge CLK);
      #1;
      edges++;
    end while (!bus.D_MEM_RDY && edges < 30);
    checkValue("rdyLatency", 32'(edges), 32'(expEdges));
    if (!holdAfter) begin
      bus.D_MEM_CSN = 1'b1;
      @(posedge CLK);
    end
  endtask

  task automatic abortAccess(input bit rd, input logic [11:0] a, input logic [31:0] d,
                             input int extra);
    @(negedge CLK);
    bus.D_MEM_CSN  = 1'b0;
    bus.D_MEM_WEN  = rd;
    bus.D_MEM_ADDR = a;
    bus.D_MEM_DOUT = d;
    bus.D_MEM_BE   = 4'hF;
    @(posedge CLK);
    repeat (extra) @(posedge CLK);
    #1;
    bus.D_MEM_CSN = 1'b1;
    repeat (LATENCY + 3) @(posedge CLK);
    #1;
    checkValue("abortRdCount", RD_COUNT, 32'(expRd));
    checkValue("abortWrCount", WR_COUNT, 32'(expWr));
  endtask

  task automatic checkOutput();
    exp_t e;
    if (expQ.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL unexpectedRdy: got RDY=1, expected no pending request");
    end else begin
      e = expQ.pop_front();
      if (e.rd) begin
        expRd++;
        lastRead = e.data;
        checkValue("readData", bus.D_MEM_DI, e.data);
      end else begin
        expWr++;
      end
      checkValue("rdCount", RD_COUNT, 32'(expRd));
      checkValue("wrCount", WR_COUNT, 32'(expWr));
    end
  endtask

  always @(negedge CLK) begin
    if (RSTn && bus.D_MEM_RDY) checkOutput();
  end

  task automatic checkResetState(input string tag);
    checkValue({tag, "Rdy"}, 32'(bus.D_MEM_RDY), 32'd0);
    checkValue({tag, "Di"}, bus.D_MEM_DI, 32'd0);
    checkValue({tag, "RdCnt"}, RD_COUNT, 32'd0);
    checkValue({tag, "WrCnt"}, WR_COUNT, 32'd0);
  endtask

  task automatic doWrite(input logic [11:0] a, input logic [31:0] d, input logic [3:0] be);
    @(negedge CLK);
    applyStimulus(1'b0, a, d, be, LATENCY + 1, 1'b0);
  endtask

  task automatic doRead(input logic [11:0] a);
    @(negedge CLK);
    applyStimulus(1'b1, a, 32'h0, 4'h0, LATENCY + 1, 1'b0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checks   = 0;
    errors   = 0;
    expRd    = 0;
    expWr    = 0;
    lastRead = '0;
    for (int i = 0; i < 4096; i++) model[i] = '0;
    RSTn           = 1'b0;
    bus.D_MEM_CSN  = 1'b1;
    bus.D_MEM_WEN  = 1'b1;
    bus.D_MEM_ADDR = '0;
    bus.D_MEM_DOUT = '0;
    bus.D_MEM_BE   = '0;
    repeat (3) @(negedge CLK);
    RSTn = 1'b1;

    for (int i = 0; i < REGION; i++) doWrite(12'(i), 32'h0, 4'hF);

    @(negedge CLK);
    RSTn = 1'b0;
    #1;
    expRd = 0;
    expWr = 0;
    lastRead = '0;
    checkResetState("reset");
    @(negedge CLK);
    RSTn = 1'b1;

    $display("[TB] full write and read-back");
    doWrite(12'h010, 32'hDEADBEEF, 4'hF);
    doRead(12'h010);
    repeat (3) @(negedge CLK);
    checkValue("heldAfterRead", bus.D_MEM_DI, 32'hDEADBEEF);
    doWrite(12'h011, 32'h55555555, 4'hF);
    checkValue("heldAfterWrite", bus.D_MEM_DI, 32'hDEADBEEF);

    $display("[TB] byte-enable write");
    doWrite(12'h010, 32'h0000AA00, 4'b0010);
    doRead(12'h010);
    checkValue("beMerge", lastRead, 32'hDEADAAEF);

    $display("[TB] aborted write");
    abortAccess(1'b0, 12'h020, 32'h12345678, 0);
    doRead(12'h020);
    checkValue("abortNoWrite", lastRead, 32'h0);
    abortAccess(1'b0, 12'h021, 32'hCAFEF00D, 1);
    doRead(12'h021);
    checkValue("lateAbortNoWrite", lastRead, 32'h0);

    $display("[TB] refill burst");
    for (int i = 0; i < 4; i++) doWrite(12'h040 + 12'(i), 32'(i + 1), 4'hF);
    @(negedge CLK);
    applyStimulus(1'b1, 12'h040, 32'h0, 4'h0, LATENCY + 1, 1'b1);
    applyStimulus(1'b1, 12'h041, 32'h0, 4'h0, LATENCY + 2, 1'b1);
    applyStimulus(1'b1, 12'h042, 32'h0, 4'h0, LATENCY + 2, 1'b1);
    applyStimulus(1'b1, 12'h043, 32'h0, 4'h0, LATENCY + 2, 1'b0);
    checkValue("burstLast", lastRead, 32'd4);

    $display("[TB] random traffic");
    for (int n = 0; n < 60; n++) begin
      int          kind;
      logic [11:0] a;
      kind = $urandom_range(0, 7);
      a    = 12'($urandom_range(0, REGION - 1));
      if (kind == 0) begin
        abortAccess(1'($urandom_range(0, 1)), a, $urandom, $urandom_range(0, 1));
      end else if (kind < 4) begin
        doRead(a);
      end else begin
        doWrite(a, $urandom, 4'($urandom_range(0, 15)));
      end
    end

    $display("[TB] reset while busy");
    @(negedge CLK);
    bus.D_MEM_CSN  = 1'b0;
    bus.D_MEM_WEN  = 1'b0;
    bus.D_MEM_ADDR = 12'h030;
    bus.D_MEM_DOUT = 32'hFFFFFFFF;
    bus.D_MEM_BE   = 4'hF;
    @(posedge CLK);
    @(negedge CLK);
    RSTn = 1'b0;
    #1;
    expRd = 0;
    expWr = 0;
    lastRead = '0;
    checkResetState("busyReset");
    bus.D_MEM_CSN = 1'b1;
    repeat (2) @(negedge CLK);
    RSTn = 1'b1;
    doRead(12'h010);
    checkValue("memKeptOverReset", lastRead, model[12'h010]);
    doRead(12'h030);

    repeat (4) @(negedge CLK);
    checkValue("queueDrained", 32'(expQ.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
